// File: rtl/noc_link_tx.sv
// noc_link_tx: drains a router input FIFO onto a credit-flow-controlled link.
// Issues reads while granted and credits remain. Forwards each flit two
// cycles after its read. Tracks head/body/tail framing so the arbiter can
// hold its grant for a whole packet, and raises sticky framing and
// credit-overflow errors.
module noc_link_tx #(
  parameter int DATA_WIDTH = 18,
  parameter int CREDITS    = 4,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           grant,
  input  logic                           fifo_empty,
  input  logic [DATA_WIDTH-1:0]          fifo_rd_data,
  output logic                           fifo_rd_en,
  output logic                           link_valid,
  output logic [DATA_WIDTH-1:0]          link_data,
  input  logic                           credit_in,
  output logic [$clog2(CREDITS+1)-1:0]   credit_cnt,
  output logic                           pkt_active,
  output logic [ADDR_WIDTH-1:0]          pkt_addr,
  output logic                           proto_err,
  output logic                           credit_err
);

  localparam int CNT_W = $clog2(CREDITS+1);
  localparam logic [CNT_W-1:0] CREDITS_C = CNT_W'(CREDITS);

  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

  logic                  rd_en;
  logic                  rd_pend_q;
  logic                  link_valid_q;
  logic [DATA_WIDTH-1:0] link_data_q;
  logic [CNT_W-1:0]      credit_q, credit_d;
  logic                  credit_err_q, credit_err_d;
  state_t                state_q;
  logic                  pkt_active_q;
  logic [ADDR_WIDTH-1:0] pkt_addr_q;
  logic                  proto_err_q;
  logic [1:0]            ftype;
  logic [ADDR_WIDTH-1:0] faddr;

  // A read needs grant, a non-empty FIFO and a free downstream slot.
  assign rd_en = grant & ~fifo_empty & (credit_q != '0);

  // Next credit count: a read and a returned credit in one cycle cancel out.
  // A credit returned while already full is an overflow and is not counted.
  always_comb begin
    credit_d     = credit_q;
    credit_err_d = credit_err_q;
    if (rd_en && !credit_in) begin
      credit_d = credit_q - 1'b1;
    end else if (!rd_en && credit_in) begin
      if (credit_q == CREDITS_C) begin
        credit_err_d = 1'b1;
      end else begin
        credit_d = credit_q + 1'b1;
      end
    end
  end

  // Credit counter and its sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_q     <= CREDITS_C;
      credit_err_q <= 1'b0;
    end else begin
      credit_q     <= credit_d;
      credit_err_q <= credit_err_d;
    end
  end

  // Read pipeline: FIFO data arrives the cycle after rd_en and is registered
  // onto the link; link_data holds its last flit while link_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_q    <= 1'b0;
      link_valid_q <= 1'b0;
      link_data_q  <= '0;
    end else begin
      rd_pend_q    <= rd_en;
      link_valid_q <= rd_pend_q;
      if (rd_pend_q) begin
        link_data_q <= fifo_rd_data;
      end
    end
  end

  assign ftype = link_data_q[DATA_WIDTH-1 -: 2];
  assign faddr = link_data_q[ADDR_WIDTH-1:0];

  // Framing FSM, stepped once per flit placed on the link.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pkt_active_q <= 1'b0;
      pkt_addr_q   <= '0;
      proto_err_q  <= 1'b0;
    end else if (link_valid_q) begin
      case (state_q)
        IDLE: begin
          case (ftype)
            FT_HEAD: begin
              pkt_addr_q   <= faddr;
              pkt_active_q <= 1'b1;
              state_q      <= IN_PKT;
            end
            FT_SINGLE: pkt_addr_q  <= faddr;
            default:   proto_err_q <= 1'b1;
          endcase
        end
        IN_PKT: begin
          case (ftype)
            FT_BODY: state_q <= IN_PKT;
            FT_TAIL: begin
              pkt_active_q <= 1'b0;
              state_q      <= IDLE;
            end
            FT_HEAD: begin
              proto_err_q <= 1'b1;
              pkt_addr_q  <= faddr;
            end
            default: begin
              proto_err_q  <= 1'b1;
              pkt_active_q <= 1'b0;
              state_q      <= IDLE;
            end
          endcase
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_rd_en = rd_en;
  assign link_valid = link_valid_q;
  assign link_data  = link_data_q;
  assign credit_cnt = credit_q;
  assign pkt_active = pkt_active_q;
  assign pkt_addr   = pkt_addr_q;
  assign proto_err  = proto_err_q;
  assign credit_err = credit_err_q;

endmodule

// File: tb/tb_noc_link_tx.sv
// Bench for noc_link_tx: a directed table, hand-written corner sequences and
// a randomized run against a flit-stream reference model.
module tb_noc_link_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        grant = 1'b0;
  logic        fifo_empty;
  logic [17:0] fifo_rd_data = '0;
  logic        fifo_rd_en;
  logic        link_valid;
  logic [17:0] link_data;
  logic        credit_in = 1'b0;
  logic [2:0]  credit_cnt;
  logic        pkt_active;
  logic [3:0]  pkt_addr;
  logic        proto_err;
  logic        credit_err;

  int total = 0;
  int bad   = 0;

  // FIFO model feeding the DUT
  logic [17:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  noc_link_tx #(.DATA_WIDTH(18), .CREDITS(4), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .grant(grant), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .link_valid(link_valid), .link_data(link_data), .credit_in(credit_in),
    .credit_cnt(credit_cnt), .pkt_active(pkt_active), .pkt_addr(pkt_addr),
    .proto_err(proto_err), .credit_err(credit_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [17:0] f);
    mem[wr_ptr] = f;
    wr_ptr++;
  endtask

  task automatic do_reset();
    grant = 1'b0;
    credit_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        grant;
    logic        cin;
    logic        rd;
    logic        lv;
    logic [17:0] data;
    logic [2:0]  cnt;
    logic        act;
    logic [3:0]  addr;
  } vec_t;

  vec_t tbl [6];

  // reference model state for the randomized run
  int          mcred;
  int          mrd;
  int          cyc;
  logic [17:0] pend_d [$];
  int          pend_t [$];
  logic        m_in, m_act, m_perr, m_cerr, exp_rd, emit;
  logic [3:0]  m_addr;
  logic [17:0] m_last, f, exp_data;

  initial begin
    int n;

    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 18'h0_0000, 3'd4, 1'b0, 4'h0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 18'h0_0000, 3'd3, 1'b0, 4'h0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 18'h1_0005, 3'd2, 1'b0, 4'h0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 18'h0_1234, 3'd1, 1'b1, 4'h5};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 18'h2_00FF, 3'd1, 1'b1, 4'h5};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 18'h2_00FF, 3'd1, 1'b0, 4'h5};

    @(negedge clk);
    do_reset();
    #1;
    chk("reset_lv",   32'(link_valid), 32'd0);
    chk("reset_cnt",  32'(credit_cnt), 32'd4);
    chk("reset_act",  32'(pkt_active), 32'd0);
    chk("reset_perr", 32'(proto_err),  32'd0);
    chk("reset_cerr", 32'(credit_err), 32'd0);
    chk("reset_data", 32'(link_data),  32'd0);

    // basic three-flit packet
    push(18'h1_0005); push(18'h0_1234); push(18'h2_00FF);
    for (int i = 0; i < 6; i++) begin
      grant = tbl[i].grant;
      credit_in = tbl[i].cin;
      #1;
      chk($sformatf("t%0d_rd", i),   32'(fifo_rd_en), 32'(tbl[i].rd));
      chk($sformatf("t%0d_lv", i),   32'(link_valid), 32'(tbl[i].lv));
      if (tbl[i].lv) chk($sformatf("t%0d_data", i), 32'(link_data), 32'(tbl[i].data));
      chk($sformatf("t%0d_cnt", i),  32'(credit_cnt), 32'(tbl[i].cnt));
      chk($sformatf("t%0d_act", i),  32'(pkt_active), 32'(tbl[i].act));
      chk($sformatf("t%0d_addr", i), 32'(pkt_addr),   32'(tbl[i].addr));
      @(negedge clk);
    end
    chk("t_hold_data", 32'(link_data), 32'h2_00FF);
    grant = 1'b0;

    // credit stall: refill, then a five-flit packet with no credits returned
    credit_in = 1'b1;
    repeat (3) @(negedge clk);
    credit_in = 1'b0;
    #1 chk("stall_refill", 32'(credit_cnt), 32'd4);
    push(18'h1_0007); push(18'h0_0001); push(18'h0_0002); push(18'h0_0003); push(18'h2_0004);
    grant = 1'b1;
    n = 0;
    repeat (8) begin
      #1 if (fifo_rd_en) n++;
      @(negedge clk);
    end
    chk("stall_reads", 32'(n), 32'd4);
    #1;
    chk("stall_cnt0", 32'(credit_cnt), 32'd0);
    chk("stall_act",  32'(pkt_active), 32'd1);
    credit_in = 1'b1;
    #1 chk("stall_pulse_rd", 32'(fifo_rd_en), 32'd0);
    @(negedge clk);
    credit_in = 1'b0;
    #1 chk("stall_resume_rd", 32'(fifo_rd_en), 32'd1);
    @(negedge clk);
    #1 chk("stall_only_one", 32'(fifo_rd_en), 32'd0);
    @(negedge clk);
    #1;
    chk("stall_tail_lv",   32'(link_valid), 32'd1);
    chk("stall_tail_data", 32'(link_data),  32'h2_0004);
    @(negedge clk);
    #1 chk("stall_act_clr", 32'(pkt_active), 32'd0);
    grant = 1'b0;

    // simultaneous read and credit return at count 2; SINGLE framing
    credit_in = 1'b1;
    repeat (2) @(negedge clk);
    credit_in = 1'b0;
    #1 chk("same_pre", 32'(credit_cnt), 32'd2);
    push(18'h3_000A);
    grant = 1'b1;
    credit_in = 1'b1;
    #1 chk("same_rd", 32'(fifo_rd_en), 32'd1);
    @(negedge clk);
    grant = 1'b0;
    credit_in = 1'b0;
    #1 chk("same_cnt", 32'(credit_cnt), 32'd2);
    @(negedge clk);
    #1 chk("single_data", 32'(link_data), 32'h3_000A);
    @(negedge clk);
    #1;
    chk("single_addr", 32'(pkt_addr),   32'hA);
    chk("single_act",  32'(pkt_active), 32'd0);
    chk("single_perr", 32'(proto_err),  32'd0);
    credit_in = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("ovf_full", 32'(credit_cnt), 32'd4);
    chk("ovf_pre",  32'(credit_err), 32'd0);
    @(negedge clk);
    credit_in = 1'b0;
    #1;
    chk("ovf_cnt", 32'(credit_cnt), 32'd4);
    chk("ovf_err", 32'(credit_err), 32'd1);
    repeat (3) @(negedge clk);
    #1 chk("ovf_sticky", 32'(credit_err), 32'd1);

    // BODY while idle
    push(18'h0_0042);
    grant = 1'b1;
    @(negedge clk);
    grant = 1'b0;
    @(negedge clk);
    #1;
    chk("body_idle_lv",   32'(link_valid), 32'd1);
    chk("body_idle_data", 32'(link_data),  32'h0_0042);
    @(negedge clk);
    #1;
    chk("body_idle_perr", 32'(proto_err),  32'd1);
    chk("body_idle_act",  32'(pkt_active), 32'd0);

    // grant dropped mid-packet
    push(18'h1_0009); push(18'h0_0055); push(18'h2_0066);
    grant = 1'b1;
    #1 chk("gdrop_head_rd", 32'(fifo_rd_en), 32'd1);
    @(negedge clk);
    grant = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1 chk($sformatf("gdrop_rd%0d", i), 32'(fifo_rd_en), 32'd0);
      if (i == 4) begin
        chk("gdrop_act",  32'(pkt_active), 32'd1);
        chk("gdrop_addr", 32'(pkt_addr),   32'h9);
      end
      @(negedge clk);
    end
    grant = 1'b1;
    repeat (2) begin
      #1 chk("gdrop_resume_rd", 32'(fifo_rd_en), 32'd1);
      @(negedge clk);
    end
    grant = 1'b0;
    #1 chk("gdrop_act_body", 32'(pkt_active), 32'd1);
    @(negedge clk);
    #1 chk("gdrop_tail", 32'(link_data), 32'h2_0066);
    @(negedge clk);
    #1 chk("gdrop_act_clr", 32'(pkt_active), 32'd0);

    // reset the cycle after a read
    do_reset();
    push(18'h1_0003);
    grant = 1'b1;
    #1 chk("rst_rd", 32'(fifo_rd_en), 32'd1);
    @(negedge clk);
    grant = 1'b0;
    rst = 1'b1;
    #1 chk("rst_async_cnt", 32'(credit_cnt), 32'd4);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      #1;
      chk("rst_lv",   32'(link_valid), 32'd0);
      chk("rst_cnt",  32'(credit_cnt), 32'd4);
      chk("rst_act",  32'(pkt_active), 32'd0);
      chk("rst_perr", 32'(proto_err),  32'd0);
      @(negedge clk);
    end

    // randomized run against the flit-stream model
    mcred = 4; mrd = rd_ptr; cyc = 0;
    m_in = 1'b0; m_act = 1'b0; m_perr = 1'b0; m_cerr = 1'b0;
    m_addr = '0; m_last = '0;
    repeat (400) begin
      if ($urandom_range(0, 9) < 4) push({2'($urandom_range(0, 3)), 16'($urandom)});
      grant = ($urandom_range(0, 9) != 0);
      credit_in = ($urandom_range(0, 9) < 3);
      #1;
      exp_rd = grant && (wr_ptr != mrd) && (mcred != 0);
      emit = (pend_t.size() > 0) && (pend_t[0] == cyc);
      exp_data = emit ? pend_d[0] : m_last;
      chk("rnd_rd",   32'(fifo_rd_en), 32'(exp_rd));
      chk("rnd_lv",   32'(link_valid), 32'(emit));
      chk("rnd_data", 32'(link_data),  32'(exp_data));
      chk("rnd_cnt",  32'(credit_cnt), 32'(mcred));
      chk("rnd_act",  32'(pkt_active), 32'(m_act));
      chk("rnd_addr", 32'(pkt_addr),   32'(m_addr));
      chk("rnd_perr", 32'(proto_err),  32'(m_perr));
      chk("rnd_cerr", 32'(credit_err), 32'(m_cerr));
      if (emit) begin
        f = pend_d.pop_front();
        void'(pend_t.pop_front());
        m_last = f;
        case (f[17:16])
          2'b01: begin if (m_in) m_perr = 1'b1; m_addr = f[3:0]; m_in = 1'b1; end
          2'b11: begin if (m_in) m_perr = 1'b1; else m_addr = f[3:0]; m_in = 1'b0; end
          2'b10: begin if (!m_in) m_perr = 1'b1; m_in = 1'b0; end
          default: if (!m_in) m_perr = 1'b1;
        endcase
        m_act = m_in;
      end
      if (exp_rd) begin
        pend_d.push_back(mem[mrd]);
        pend_t.push_back(cyc + 2);
        mrd++;
      end
      if (exp_rd && !credit_in) mcred--;
      else if (!exp_rd && credit_in) begin
        if (mcred == 4) m_cerr = 1'b1;
        else mcred++;
      end
      cyc++;
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
